gxb_reset_sequencer: RTL

Parametrised reset and calibration sequencer for an N-lane transceiver PCIe subsystem.
- Replaces the hard-wired `!pll_locked` offset-cancellation hookup with a timed, supervised state machine.
- Sequence: PLL powerdown, PLL lock, offset-cancellation calibration via altgxb_reconfig busy, transceiver powerup, then staggered per-lane reset release.
- Adds timeouts, bounded retry, a sticky fault, and a debounced button soft reset.
- Sits beside the PLL and reconfig controller at top level, on the reconfig clock.

---
 rtl/gxb_reset_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/gxb_reset_sequencer.sv
// gxb_reset_sequencer: supervised reset/calibration sequencer for an N-lane
// transceiver. It runs PLL powerdown, PLL lock, offset cancellation and
// transceiver powerup, then releases the lane resets one at a time. Waiting
// states time out and retry a bounded number of times before a sticky fault.
//
// Ports (all logic on reconfig_gxbclk_clk):
//   pcie_rstn                 async active-low reset
//   pll_locked                PLL lock (async, synchronised here)
//   busy_altgxb_reconfig      reconfig busy (async, synchronised here)
//   lane_en[N_LANES]          lane enable mask, captured on LANE_REL entry
//   soft_rst_btn              raw active-low button (synchronised, debounced)
//   offset_cancellation_reset active-high reset to altgxb_reconfig
//   pll_powerdown             active-high
//   gxb_powerdown             active-high
//   lane_rstn[N_LANES]        per-lane active-low reset
//   seq_done / seq_fault      high in RUN / FAULT
//   retry_cnt[RETRY_W]        saturating count of ERROR entries
//   leds[4]                   current state code
module gxb_reset_sequencer #(
  parameter int unsigned N_LANES      = 1,
  parameter int unsigned PD_CYCLES    = 64,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned TIMEOUT      = 65536,
  parameter int unsigned RELEASE_DLY  = 128,
  parameter int unsigned LANE_STAGGER = 16,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned DEBOUNCE     = 500000,
  parameter int unsigned RETRY_W      = 4
) (
  input  logic               reconfig_gxbclk_clk,
  input  logic               pcie_rstn,
  input  logic               pll_locked,
  input  logic               busy_altgxb_reconfig,
  input  logic [N_LANES-1:0] lane_en,
  input  logic               soft_rst_btn,
  output logic               offset_cancellation_reset,
  output logic               pll_powerdown,
  output logic               gxb_powerdown,
  output logic [N_LANES-1:0] lane_rstn,
  output logic               seq_done,
  output logic               seq_fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [3:0]         leds
);

  localparam int unsigned M_A     = (PD_CYCLES > LOCK_STABLE) ? PD_CYCLES : LOCK_STABLE;
  localparam int unsigned M_B     = (RELEASE_DLY > LANE_STAGGER) ? RELEASE_DLY : LANE_STAGGER;
  localparam int unsigned DLY_MAX = (M_A > M_B) ? M_A : M_B;
  localparam int unsigned DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam int unsigned TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE + 1);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_WAIT_LOCK = 4'd1,
    S_CAL_START = 4'd2,
    S_CAL_BUSY  = 4'd3,
    S_GXB_UP    = 4'd4,
    S_LANE_REL  = 4'd5,
    S_RUN       = 4'd6,
    S_ERROR     = 4'd7,
    S_FAULT     = 4'd8
  } state_e;

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic [N_LANES-1:0] mask_q, mask_d, lane_rstn_q, lane_rstn_d, pending, lowest;
  logic               ocr_q, ocr_d, pll_pd_q, pll_pd_d, gxb_pd_q, gxb_pd_d;
  logic               done_q, done_d, fault_q, fault_d;
  logic [3:0]         leds_q, leds_d;
  logic               lock_meta_q, lock_s_q, busy_meta_q, busy_s_q, btn_meta_q, btn_s_q;
  logic               soft_pulse, tmo_hit;

  // Counter saturates at DEBOUNCE, so a held button fires exactly once.
  always_comb begin
    deb_d = deb_q;
    if (btn_s_q) deb_d = '0;
    else if (deb_q != DEB_W'(DEBOUNCE)) deb_d = deb_q + DEB_W'(1);
  end
  assign soft_pulse = !btn_s_q && (deb_q == DEB_W'(DEBOUNCE - 1));

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q + DLY_W'(1);
    tmo_d       = tmo_q + TMO_W'(1);
    retry_d     = retry_q;
    mask_d      = mask_q;
    lane_rstn_d = lane_rstn_q;
    pending     = mask_q & ~lane_rstn_q;
    lowest      = pending & (~pending + N_LANES'(1));
    retry_inc   = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
    tmo_hit     = (tmo_q == TMO_W'(TIMEOUT - 1));

    case (state_q)
      S_RESET: if (dly_q == DLY_W'(PD_CYCLES - 1)) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (!lock_s_q) dly_d = '0;
        else if (dly_q == DLY_W'(LOCK_STABLE - 1)) state_d = S_CAL_START;
        if (state_d == S_WAIT_LOCK && tmo_hit) state_d = S_ERROR;
      end
      S_CAL_START: begin
        if (!lock_s_q) state_d = S_ERROR;
        else if (busy_s_q) state_d = S_CAL_BUSY;
        else if (tmo_hit) state_d = S_ERROR;
      end
      S_CAL_BUSY: begin
        if (!lock_s_q) state_d = S_ERROR;
        else if (!busy_s_q) state_d = S_GXB_UP;
        else if (tmo_hit) state_d = S_ERROR;
      end
      S_GXB_UP: begin
        if (!lock_s_q) state_d = S_ERROR;
        else if (dly_q == DLY_W'(RELEASE_DLY - 1)) begin
          state_d = S_LANE_REL;
          mask_d  = lane_en;
        end
      end
      S_LANE_REL: begin
        if (!lock_s_q) state_d = S_ERROR;
        else begin
          // dly_q == 0 marks a release slot; the entry cycle is the first one.
          if (dly_q == '0) begin
            lane_rstn_d = lane_rstn_q | lowest;
            if ((pending & ~lowest) == '0) state_d = S_RUN;
          end
          if (dly_q == DLY_W'(LANE_STAGGER - 1)) dly_d = '0;
        end
      end
      S_RUN: if (!lock_s_q) state_d = S_RESET;
      S_ERROR: begin
        retry_d = retry_inc;
        state_d = (32'(retry_inc) >= MAX_RETRY) ? S_FAULT : S_RESET;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_RESET;
    endcase

    if (soft_pulse) begin
      state_d = S_RESET;
      retry_d = '0;
    end
    if (!(state_d inside {S_LANE_REL, S_RUN})) lane_rstn_d = '0;
    if (state_d != state_q || soft_pulse) begin
      dly_d = '0;
      tmo_d = '0;
    end

    // Outputs decode the current state and are registered, so they trail it by one cycle.
    pll_pd_d = state_q inside {S_RESET, S_ERROR, S_FAULT};
    ocr_d    = !(state_q inside {S_CAL_START, S_CAL_BUSY, S_GXB_UP, S_LANE_REL, S_RUN});
    gxb_pd_d = !(state_q inside {S_GXB_UP, S_LANE_REL, S_RUN});
    done_d   = (state_q == S_RUN);
    fault_d  = (state_q == S_FAULT);
    leds_d   = state_q;
  end

  always_ff @(posedge reconfig_gxbclk_clk or negedge pcie_rstn) begin
    if (!pcie_rstn) begin
      state_q     <= S_RESET;
      dly_q       <= '0;
      tmo_q       <= '0;
      deb_q       <= '0;
      retry_q     <= '0;
      mask_q      <= '0;
      lane_rstn_q <= '0;
      ocr_q       <= 1'b1;
      pll_pd_q    <= 1'b1;
      gxb_pd_q    <= 1'b1;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      leds_q      <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
      btn_meta_q  <= 1'b1;
      btn_s_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      tmo_q       <= tmo_d;
      deb_q       <= deb_d;
      retry_q     <= retry_d;
      mask_q      <= mask_d;
      lane_rstn_q <= lane_rstn_d;
      ocr_q       <= ocr_d;
      pll_pd_q    <= pll_pd_d;
      gxb_pd_q    <= gxb_pd_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      leds_q      <= leds_d;
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
      busy_meta_q <= busy_altgxb_reconfig;
      busy_s_q    <= busy_meta_q;
      btn_meta_q  <= soft_rst_btn;
      btn_s_q     <= btn_meta_q;
    end
  end

  assign offset_cancellation_reset = ocr_q;
  assign pll_powerdown             = pll_pd_q;
  assign gxb_powerdown             = gxb_pd_q;
  assign lane_rstn                 = lane_rstn_q;
  assign seq_done                  = done_q;
  assign seq_fault                 = fault_q;
  assign retry_cnt                 = retry_q;
  assign leds                      = leds_q;

endmodule
